// File: rtl/rdma_tx_pkt_mux_if.sv
// ---------------------------------------------------------------------------
// rdma_tx_pkt_mux_if : AXI4-Stream bundle used by the RDMA TX packet mux.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rdma_tx_pkt_mux_if #(
  parameter int DATA_W = 512
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tuser;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tuser, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

`default_nettype wire

// File: rtl/rdma_tx_pkt_mux.sv
// ---------------------------------------------------------------------------
// rdma_tx_pkt_mux : packet-atomic merge of XRNIC (RoCE) and DMA TX streams
//                   into one registered stream; optional RDMA_TX_STRICT_PRIO_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rdma_tx_pkt_mux #(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 32
) (
  input  logic                  core_clk,
  input  logic                  core_rst,
  rdma_tx_pkt_mux_if.slave      xrnic_s_axis,
  rdma_tx_pkt_mux_if.slave      dma_s_axis,
  rdma_tx_pkt_mux_if.master     m_axis,
  output logic [CNT_W-1:0]      xrnic_pkt_cnt,
  output logic [CNT_W-1:0]      dma_pkt_cnt
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_XRNIC = 2'd1;
  localparam logic [1:0] c_ST_DMA   = 2'd2;

  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_tdata;
  logic [DATA_W/8-1:0] r_tkeep;
  logic                r_tlast;
  logic                r_tuser;
  logic                r_tvalid;
  logic [CNT_W-1:0]    r_xrnic_cnt;
  logic [CNT_W-1:0]    r_dma_cnt;

  logic w_slot_free;
  logic w_pick_x;
  logic w_sel_x;
  logic w_sel_d;
  logic w_acc_x;
  logic w_acc_d;
  logic w_acc;
  logic w_acc_last;

`ifdef RDMA_TX_STRICT_PRIO_EN
  assign w_pick_x = 1'b1;
`else
  // High after a DMA packet completes, so XRNIC wins the next contention.
  logic r_last_grant_dma;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_last_grant_dma <= 1'b1;
    end else if (w_acc_last) begin
      r_last_grant_dma <= w_acc_d;
    end
  end

  assign w_pick_x = r_last_grant_dma;
`endif

  assign w_slot_free = !r_tvalid || m_axis.tready;

  always_comb begin
    w_sel_x = 1'b0;
    w_sel_d = 1'b0;
    case (r_state)
      c_ST_XRNIC: w_sel_x = 1'b1;
      c_ST_DMA:   w_sel_d = 1'b1;
      default: begin
        if (xrnic_s_axis.tvalid && dma_s_axis.tvalid) begin
          w_sel_x = w_pick_x;
          w_sel_d = !w_pick_x;
        end else begin
          w_sel_x = xrnic_s_axis.tvalid;
          w_sel_d = dma_s_axis.tvalid;
        end
      end
    endcase
  end

  assign xrnic_s_axis.tready = w_sel_x && w_slot_free && !core_rst;
  assign dma_s_axis.tready   = w_sel_d && w_slot_free && !core_rst;

  assign w_acc_x    = xrnic_s_axis.tvalid && xrnic_s_axis.tready;
  assign w_acc_d    = dma_s_axis.tvalid && dma_s_axis.tready;
  assign w_acc      = w_acc_x || w_acc_d;
  assign w_acc_last = w_acc_d ? dma_s_axis.tlast : (w_acc_x && xrnic_s_axis.tlast);

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      r_state     <= c_ST_IDLE;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_tvalid    <= 1'b0;
      r_xrnic_cnt <= '0;
      r_dma_cnt   <= '0;
    end else if (w_acc) begin
      r_tvalid <= 1'b1;
      r_tdata  <= w_acc_d ? dma_s_axis.tdata : xrnic_s_axis.tdata;
      r_tkeep  <= w_acc_d ? dma_s_axis.tkeep : xrnic_s_axis.tkeep;
      r_tuser  <= w_acc_d ? dma_s_axis.tuser : xrnic_s_axis.tuser;
      r_tlast  <= w_acc_last;
      if (w_acc_last) begin
        r_state <= c_ST_IDLE;
        if (w_acc_d) begin
          r_dma_cnt <= r_dma_cnt + 1'b1;
        end else begin
          r_xrnic_cnt <= r_xrnic_cnt + 1'b1;
        end
      end else begin
        r_state <= w_acc_d ? c_ST_DMA : c_ST_XRNIC;
      end
    end else if (w_slot_free) begin
      // Locked source bubbles drain here without releasing the lock.
      r_tvalid <= 1'b0;
    end
  end

  assign m_axis.tdata   = r_tdata;
  assign m_axis.tkeep   = r_tkeep;
  assign m_axis.tlast   = r_tlast;
  assign m_axis.tuser   = r_tuser;
  assign m_axis.tvalid  = r_tvalid;
  assign xrnic_pkt_cnt  = r_xrnic_cnt;
  assign dma_pkt_cnt    = r_dma_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rdma_tx_pkt_mux.sv
// ---------------------------------------------------------------------------
// tb_rdma_tx_pkt_mux : vector table, directed corner sequences and random
//                      packet traffic against a per-source packet model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rdma_tx_pkt_mux;

  localparam int DW = 64;
  localparam int CW = 4;

  logic core_clk = 1'b0;
  logic core_rst = 1'b1;
  logic [CW-1:0] x_cnt;
  logic [CW-1:0] d_cnt;

  always #5 core_clk = ~core_clk;

  rdma_tx_pkt_mux_if #(.DATA_W(DW)) x_if ();
  rdma_tx_pkt_mux_if #(.DATA_W(DW)) d_if ();
  rdma_tx_pkt_mux_if #(.DATA_W(DW)) m_if ();

  rdma_tx_pkt_mux #(.DATA_W(DW), .CNT_W(CW)) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .xrnic_s_axis  (x_if),
    .dma_s_axis    (d_if),
    .m_axis        (m_if),
    .xrnic_pkt_cnt (x_cnt),
    .dma_pkt_cnt   (d_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // in = {xv, xl, dv, dl, m_ready}; ex = {x_ready, d_ready, m_valid, m_last}
  typedef struct packed {
    logic [4:0]  in;
    logic [63:0] xd;
    logic [63:0] dd;
    logic [3:0]  ex;
    logic [63:0] emd;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // keep and user are derived from data so pass-through is visible in every beat
  task automatic drive(input logic [4:0] f, input logic [63:0] xd, input logic [63:0] dd);
    x_if.tvalid = f[4]; x_if.tlast = f[3]; x_if.tdata = xd; x_if.tkeep = xd[7:0]; x_if.tuser = xd[0];
    d_if.tvalid = f[2]; d_if.tlast = f[1]; d_if.tdata = dd; d_if.tkeep = dd[7:0]; d_if.tuser = dd[0];
    m_if.tready = f[0];
  endtask

  task automatic cyc(input vec_t v, input string tag);
    drive(v.in, v.xd, v.dd);
    #4;
    chk({tag, ".xrdy"}, 128'(x_if.tready), 128'(v.ex[3]));
    chk({tag, ".drdy"}, 128'(d_if.tready), 128'(v.ex[2]));
    @(posedge core_clk); #1;
    chk({tag, ".mvld"}, 128'(m_if.tvalid), 128'(v.ex[1]));
    if (v.ex[1])
      chk({tag, ".mbeat"}, 128'({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}),
          128'({v.emd, v.emd[7:0], v.emd[0], v.ex[0]}));
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    drive(5'b10100, 64'h5, 64'h6);
    @(posedge core_clk); #1;
    @(posedge core_clk); #1;
    chk("rst.xrdy", 128'(x_if.tready), 128'(0));
    chk("rst.drdy", 128'(d_if.tready), 128'(0));
    chk("rst.mout", 128'({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata}), 128'(0));
    chk("rst.cnt", 128'({x_cnt, d_cnt}), 128'(0));
    core_rst = 1'b0;
    drive(5'b00001, 64'h0, 64'h0);
  endtask

  task automatic run_random();
    beat_t gx[$], gd[$], ex_x[$], ex_d[$];
    beat_t b, e;
    logic xh, dh, xa, da, in_pkt, cur, s;
    int mx, md, cycles, len;
    xh = 0; dh = 0; xa = 0; da = 0; in_pkt = 0; cur = 0;
    mx = 0; md = 0; cycles = 0;
    for (int src = 0; src < 2; src++) begin
      for (int p = 0; p < 20; p++) begin
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          b.d = {src[0], p[14:0], k[15:0], 32'($urandom)};
          b.l = (k == len - 1);
          if (src == 1) begin gx.push_back(b); ex_x.push_back(b); end
          else begin gd.push_back(b); ex_d.push_back(b); end
        end
      end
    end
    while ((ex_x.size() + ex_d.size()) > 0 && cycles < 3000) begin
      if (xa) begin void'(gx.pop_front()); xh = 0; end
      if (da) begin void'(gd.pop_front()); dh = 0; end
      if (!xh && gx.size() > 0 && $urandom_range(0, 9) < 7) xh = 1;
      if (!dh && gd.size() > 0 && $urandom_range(0, 9) < 7) dh = 1;
      x_if.tvalid = xh;
      if (xh) begin
        x_if.tdata = gx[0].d; x_if.tkeep = gx[0].d[7:0]; x_if.tuser = gx[0].d[0]; x_if.tlast = gx[0].l;
      end
      d_if.tvalid = dh;
      if (dh) begin
        d_if.tdata = gd[0].d; d_if.tkeep = gd[0].d[7:0]; d_if.tuser = gd[0].d[0]; d_if.tlast = gd[0].l;
      end
      m_if.tready = ($urandom_range(0, 3) != 0);
      #4;
      xa = x_if.tvalid && x_if.tready;
      da = d_if.tvalid && d_if.tready;
      if (m_if.tvalid && m_if.tready) begin
        s = m_if.tdata[63];
        if (in_pkt) chk("rnd.atomic", 128'(s), 128'(cur));
        cur = s;
        in_pkt = !m_if.tlast;
        if ((s && ex_x.size() == 0) || (!s && ex_d.size() == 0)) begin
          chk("rnd.extra_beat", 128'(1), 128'(0));
        end else begin
          if (s) e = ex_x.pop_front(); else e = ex_d.pop_front();
          chk("rnd.beat", 128'({m_if.tdata, m_if.tkeep, m_if.tuser, m_if.tlast}),
              128'({e.d, e.d[7:0], e.d[0], e.l}));
          if (e.l) begin
            if (s) mx++; else md++;
          end
        end
      end
      @(posedge core_clk); #1;
      cycles++;
    end
    chk("rnd.timeout", 128'(cycles < 3000), 128'(1));
    drive(5'b00001, 64'h0, 64'h0);
    @(posedge core_clk); #1;
    chk("rnd.xcnt", 128'(x_cnt), 128'(mx[CW-1:0]));
    chk("rnd.dcnt", 128'(d_cnt), 128'(md[CW-1:0]));
  endtask

  initial begin
`ifdef RDMA_TX_STRICT_PRIO_EN
    tbl[0] = {5'b10101, 64'h11, 64'h21, 4'b1010, 64'h11};
    tbl[1] = {5'b11101, 64'h12, 64'h21, 4'b1011, 64'h12};
    tbl[2] = {5'b10101, 64'h13, 64'h21, 4'b1010, 64'h13};
    tbl[3] = {5'b11101, 64'h14, 64'h21, 4'b1011, 64'h14};
    tbl[4] = {5'b00101, 64'h0,  64'h21, 4'b0110, 64'h21};
    tbl[5] = {5'b00111, 64'h0,  64'h22, 4'b0111, 64'h22};
    tbl[6] = {5'b00001, 64'h0,  64'h0,  4'b0000, 64'h0};
    tbl[7] = {5'b00001, 64'h0,  64'h0,  4'b0000, 64'h0};
    tbl[8] = {5'b00001, 64'h0,  64'h0,  4'b0000, 64'h0};
`else
    tbl[0] = {5'b10101, 64'h11, 64'h21, 4'b1010, 64'h11};
    tbl[1] = {5'b11101, 64'h12, 64'h21, 4'b1011, 64'h12};
    tbl[2] = {5'b10101, 64'h13, 64'h21, 4'b0110, 64'h21};
    tbl[3] = {5'b10111, 64'h13, 64'h22, 4'b0111, 64'h22};
    tbl[4] = {5'b10101, 64'h13, 64'h23, 4'b1010, 64'h13};
    tbl[5] = {5'b11101, 64'h14, 64'h23, 4'b1011, 64'h14};
    tbl[6] = {5'b00101, 64'h0,  64'h23, 4'b0110, 64'h23};
    tbl[7] = {5'b00111, 64'h0,  64'h24, 4'b0111, 64'h24};
    tbl[8] = {5'b00001, 64'h0,  64'h0,  4'b0000, 64'h0};
`endif
    drive(5'b00000, 64'h0, 64'h0);
    @(posedge core_clk); #1;

    // contention after reset, back-to-back packets
    do_reset();
    for (int i = 0; i < 9; i++) cyc(tbl[i], $sformatf("tbl%0d", i));
`ifdef RDMA_TX_STRICT_PRIO_EN
    chk("tbl.cnt", 128'({x_cnt, d_cnt}), 128'({4'd2, 4'd1}));
`else
    chk("tbl.cnt", 128'({x_cnt, d_cnt}), 128'({4'd2, 4'd2}));
`endif

    // single 3-beat XRNIC packet
    do_reset();
    cyc({5'b10001, 64'hA01, 64'h0, 4'b1010, 64'hA01}, "sx1");
    cyc({5'b10001, 64'hA02, 64'h0, 4'b1010, 64'hA02}, "sx2");
    cyc({5'b11001, 64'hAFF, 64'h0, 4'b1011, 64'hAFF}, "sx3");
    cyc({5'b00001, 64'h0,   64'h0, 4'b0000, 64'h0},   "sx4");
    chk("sx.cnt", 128'({x_cnt, d_cnt}), 128'({4'd1, 4'd0}));

    // backpressure during a 4-beat DMA packet
    do_reset();
    cyc({5'b00101, 64'h0,  64'h31, 4'b0110, 64'h31}, "bp1");
    cyc({5'b10100, 64'h99, 64'h32, 4'b0010, 64'h31}, "bp2");
    cyc({5'b10100, 64'h99, 64'h32, 4'b0010, 64'h31}, "bp3");
    cyc({5'b00101, 64'h0,  64'h32, 4'b0110, 64'h32}, "bp4");
    cyc({5'b00101, 64'h0,  64'h33, 4'b0110, 64'h33}, "bp5");
    cyc({5'b00111, 64'h0,  64'h34, 4'b0111, 64'h34}, "bp6");
    cyc({5'b00001, 64'h0,  64'h0,  4'b0000, 64'h0},  "bp7");

    // DMA gap mid-packet with XRNIC waiting
    cyc({5'b00101, 64'h0,  64'h41, 4'b0110, 64'h41}, "gap1");
    cyc({5'b10101, 64'h51, 64'h42, 4'b0110, 64'h42}, "gap2");
    cyc({5'b10001, 64'h51, 64'h0,  4'b0100, 64'h0},  "gap3");
    cyc({5'b10001, 64'h51, 64'h0,  4'b0100, 64'h0},  "gap4");
    cyc({5'b10111, 64'h51, 64'h43, 4'b0111, 64'h43}, "gap5");
    cyc({5'b11001, 64'h51, 64'h0,  4'b1011, 64'h51}, "gap6");
    chk("gap.cnt", 128'({x_cnt, d_cnt}), 128'({4'd1, 4'd2}));

    // reset on beat 2 of a 5-beat packet; last grant was XRNIC beforehand
    cyc({5'b10001, 64'h61, 64'h0, 4'b1010, 64'h61}, "mr1");
    core_rst = 1'b1;
    cyc({5'b10101, 64'h62, 64'h71, 4'b0000, 64'h0}, "mr2");
    chk("mr.cnt", 128'({x_cnt, d_cnt}), 128'(0));
    chk("mr.data", 128'({m_if.tdata, m_if.tkeep}), 128'(0));
    core_rst = 1'b0;
    cyc({5'b00001, 64'h0,  64'h0,  4'b0000, 64'h0},  "mr3");
    cyc({5'b11111, 64'h63, 64'h72, 4'b1011, 64'h63}, "mr4");
    cyc({5'b00111, 64'h0,  64'h72, 4'b0111, 64'h72}, "mr5");

    // counter wrap at CW=4: 17 single-beat DMA packets
    do_reset();
    for (int i = 0; i < 17; i++)
      cyc({5'b00111, 64'h0, 64'(100 + i), 4'b0111, 64'(100 + i)}, $sformatf("wrap%0d", i));
    chk("wrap.dcnt", 128'(d_cnt), 128'(1));
    chk("wrap.xcnt", 128'(x_cnt), 128'(0));

    do_reset();
    run_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
